// File: rtl/fifo_rd_pkg.sv
// Shared state type, latency bound and counter-width helper for the FIFO read streamer.
package fifo_rd_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} rd_state_t;

   localparam int RD_LAT_MAX = 3;

   // Bits needed to hold every value in 0..n inclusive.
   function automatic int clog2p1(input int n);
      int w;
      w = 1;
      while ((1 << w) <= n) w++;
      return w;
   endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Circular skid store of DEPTH words with push/pop and occupancy; head word is always on head_data.
// Push and pop share an edge without changing occupancy; pop only happens with words stored.
module fifo_rd_skid
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int OCC_W = clog2p1(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [OCC_W-1:0] occ
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         if (push && !pop)      occ <= occ + 1'b1;
         else if (pop && !push) occ <= occ - 1'b1;
      end
   end

   assign head_data = mem[rd_ptr];

   // The issue rule upstream reserves a slot for every read, so a full store never sees a push.
   assert property (@(posedge clk) disable iff (rst) !(push && occ == FULL));

endmodule

// File: rtl/fifo_rd_streamer.sv
// Pulls words from asyn_fifo, hides its RD_LAT return delay behind a skid store, emits valid/ready; first m_valid RD_LAT+1 cycles after fifo_re.
// Reads pause once SKID words are stored or in flight, so m_ready may stall indefinitely; FIFO_RD_CNT_EN adds the words_rd counter.
module fifo_rd_streamer
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int RD_LAT = 1
`ifdef FIFO_RD_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             rd_en,
   input  logic             fifo_empty,
   output logic             fifo_re,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CNT_W-1:0] words_rd
`endif
);

   localparam int SKID = RD_LAT + 1;
   localparam int CW   = clog2p1(SKID);
   localparam logic [CW:0] SKID_V = (CW + 1)'(SKID);

   rd_state_t     state_q;
   rd_state_t     state_d;
   logic [CW-1:0] occ;
   logic [CW-1:0] infl;
   logic [CW:0]   outstanding;
   logic          push;
   logic          pop;

   // Each bit marks a read issued k+1 edges ago; the oldest bit lines up with its returning word.
   if (RD_LAT == 0) begin : g_nolat
      assign push = fifo_re;
      assign infl = '0;
   end else begin : g_lat
      logic [RD_LAT-1:0] sr;
      always_ff @(posedge rclk) begin
         if (rrst) begin
            sr <= '0;
         end else begin
            sr[0] <= fifo_re;
            for (int i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
         end
      end
      assign push = sr[RD_LAT-1];
      assign infl = CW'($countones(sr));
   end

   assign outstanding = {1'b0, occ} + {1'b0, infl};
   assign m_valid     = (occ != '0);
   assign pop         = m_valid && m_ready;

   always_ff @(posedge rclk) begin
      if (rrst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      fifo_re = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rd_en) state_d = FETCH;
         end
         FETCH: begin
            fifo_re = rd_en && !fifo_empty && (outstanding < SKID_V);
            if (!rd_en) state_d = (infl != '0) ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (infl == '0) state_d = rd_en ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   fifo_rd_skid #(
      .WIDTH (WIDTH),
      .DEPTH (SKID)
   ) u_skid (
      .clk       (rclk),
      .rst       (rrst),
      .push      (push),
      .push_data (fifo_data),
      .pop       (pop),
      .head_data (m_data),
      .occ       (occ)
   );

`ifdef FIFO_RD_CNT_EN
   always_ff @(posedge rclk) begin
      if (rrst)     words_rd <= '0;
      else if (pop) words_rd <= words_rd + 1'b1;
   end
`endif

   assert property (@(posedge rclk) RD_LAT <= RD_LAT_MAX);

endmodule
